// File: rtl/kl_pipe_pkg.sv
// Shared pipeline definitions: memory opcodes and the data-memory grant state.
package kl_pipe_pkg;

  localparam logic [2:0] OP_LDR = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;

  typedef enum logic {
    GRANT_P0,
    GRANT_P1
  } dmem_grant_t;

  function automatic logic is_mem_op(input logic [2:0] opcode);
    return (opcode == OP_LDR) || (opcode == OP_STR);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundles the two S3 slots, their load results and the shared data-memory bus.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic [2:0]        p0S3_opcode;
  logic [ADDR_W-1:0] p0S3_addr;
  logic [DATA_W-1:0] p0S3_wdata;
  logic [2:0]        p1S3_opcode;
  logic [ADDR_W-1:0] p1S3_addr;
  logic [DATA_W-1:0] p1S3_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              mem_stall;
  logic              mem_timeout;

  // Handshake: mem_read/mem_write is the request and is held with stable
  // addr/wdata until a cycle in which mem_ready=1, which completes it.
  modport slave (
    input  p0S3_opcode, p0S3_addr, p0S3_wdata,
    input  p1S3_opcode, p1S3_addr, p1S3_wdata,
    input  mem_rdata, mem_ready,
    output mem_addr, mem_wdata, mem_read, mem_write,
    output p0_rdata, p1_rdata, mem_stall, mem_timeout
  );

  modport master (
    output p0S3_opcode, p0S3_addr, p0S3_wdata,
    output p1S3_opcode, p1S3_addr, p1S3_wdata,
    output mem_rdata, mem_ready,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    input  p0_rdata, p1_rdata, mem_stall, mem_timeout
  );

endinterface

// File: rtl/dmem_port_arbiter_watchdog.sv
// Counts consecutive not-ready cycles of one access and raises a sticky flag
// once the count reaches TIMEOUT.
module dmem_wait_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy_i,
  input  logic ready_i,
  input  logic restart_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    // An idle port or a completed/regranted access starts a fresh count.
    if (!busy_i || ready_i || restart_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == LIMIT) begin
      to_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serializes the P0/P1 S3 memory accesses onto one data-memory port, P0 first,
// stalling the pipeline until the whole pair has retired.
module dmem_port_arbiter
  import kl_pipe_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_port_arbiter_if.slave bus,
  output dmem_grant_t       state_o,
  output logic [DATA_W-1:0] hold_o
);

  dmem_grant_t       state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              mem0, mem1;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rd, wr;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              stall;
  logic              timeout;

  assign mem0 = is_mem_op(bus.p0S3_opcode);
  assign mem1 = is_mem_op(bus.p1S3_opcode);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    addr     = '0;
    wdata    = '0;
    rd       = 1'b0;
    wr       = 1'b0;
    p0_rdata = '0;
    p1_rdata = '0;
    stall    = 1'b0;
    unique case (state_q)
      GRANT_P0: begin
        if (mem0) begin
          addr  = bus.p0S3_addr;
          wdata = bus.p0S3_wdata;
          rd    = (bus.p0S3_opcode == OP_LDR);
          wr    = (bus.p0S3_opcode == OP_STR);
          if (!bus.mem_ready) begin
            stall = 1'b1;
          end else if (mem1) begin
            // P0 is done; park its load data until P1 retires with it.
            hold_d  = bus.mem_rdata;
            state_d = GRANT_P1;
            stall   = 1'b1;
          end else begin
            p0_rdata = bus.mem_rdata;
          end
        end else if (mem1) begin
          addr     = bus.p1S3_addr;
          wdata    = bus.p1S3_wdata;
          rd       = (bus.p1S3_opcode == OP_LDR);
          wr       = (bus.p1S3_opcode == OP_STR);
          stall    = ~bus.mem_ready;
          p1_rdata = bus.mem_rdata;
        end
      end
      GRANT_P1: begin
        addr     = bus.p1S3_addr;
        wdata    = bus.p1S3_wdata;
        rd       = (bus.p1S3_opcode == OP_LDR);
        wr       = (bus.p1S3_opcode == OP_STR);
        p0_rdata = hold_q;
        p1_rdata = bus.mem_rdata;
        if (bus.mem_ready) begin
          state_d = GRANT_P0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = GRANT_P0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GRANT_P0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  dmem_wait_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy_i    (rd | wr),
    .ready_i   (bus.mem_ready),
    .restart_i (state_d != state_q),
    .timeout_o (timeout)
  );

  assign bus.mem_addr    = addr;
  assign bus.mem_wdata   = wdata;
  assign bus.mem_read    = rd;
  assign bus.mem_write   = wr;
  assign bus.p0_rdata    = p0_rdata;
  assign bus.p1_rdata    = p1_rdata;
  assign bus.mem_stall   = stall;
  assign bus.mem_timeout = timeout;
  assign state_o         = state_q;
  assign hold_o          = hold_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a pair-level reference model and
// a behavioural data memory.
module tb_dmem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 4;

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] LDR = 3'b011;
  localparam logic [2:0] STR = 3'b100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  kl_pipe_pkg::dmem_grant_t state_o;
  logic [DW-1:0]            hold_o;

  dmem_port_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state_o),
    .hold_o  (hold_o)
  );

  // ---------------- behavioural memory ----------------
  logic [DW-1:0] mem [256] = '{default: '0};
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_write && bus.mem_ready) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Pair-level model: p0_served says P0's half of a two-access pair is done.
  logic [DW-1:0] shadow [256] = '{default: '0};
  logic          m_valid = 1'b0;
  logic          p0_served = 1'b0;
  logic [DW-1:0] m_hold = '0;
  int            m_wait = 0;
  logic          m_to = 1'b0;

  logic          m0, m1, e_read, e_write, e_stall, e_access;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_p0, e_p1, cap;
  logic          cap_en;

  always @(negedge clk) begin
    m0 = (bus.p0S3_opcode == LDR) || (bus.p0S3_opcode == STR);
    m1 = (bus.p1S3_opcode == LDR) || (bus.p1S3_opcode == STR);
    e_addr = '0; e_wdata = '0; e_read = 1'b0; e_write = 1'b0;
    e_p0 = '0; e_p1 = '0; e_stall = 1'b0; cap_en = 1'b0; cap = '0;
    if (p0_served || (!m0 && m1)) begin
      e_addr  = bus.p1S3_addr;
      e_wdata = bus.p1S3_wdata;
      e_read  = (bus.p1S3_opcode == LDR);
      e_write = (bus.p1S3_opcode == STR);
      e_p1    = shadow[bus.p1S3_addr];
      e_p0    = p0_served ? m_hold : '0;
      e_stall = !bus.mem_ready;
    end else if (m0) begin
      e_addr  = bus.p0S3_addr;
      e_wdata = bus.p0S3_wdata;
      e_read  = (bus.p0S3_opcode == LDR);
      e_write = (bus.p0S3_opcode == STR);
      e_stall = !bus.mem_ready || m1;
      if (bus.mem_ready && !m1) e_p0 = shadow[bus.p0S3_addr];
      if (bus.mem_ready && m1) begin
        cap_en = 1'b1;
        cap    = shadow[bus.p0S3_addr];
      end
    end
    e_access = e_read || e_write;

    if (m_valid) begin
      check("mem_addr",    32'(bus.mem_addr),    32'(e_addr));
      check("mem_read",    32'(bus.mem_read),    32'(e_read));
      check("mem_write",   32'(bus.mem_write),   32'(e_write));
      if (e_write) check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
      check("p0_rdata",    32'(bus.p0_rdata),    32'(e_p0));
      check("p1_rdata",    32'(bus.p1_rdata),    32'(e_p1));
      check("mem_stall",   32'(bus.mem_stall),   32'(e_stall));
      check("mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
      check("grant_state", 32'(state_o),         32'(p0_served));
      check("hold_reg",    32'(hold_o),          32'(m_hold));
    end

    // advance the model to the next cycle
    if (pre_en) shadow[pre_addr] = pre_data;
    if (m_valid && e_write && bus.mem_ready) shadow[e_addr] = e_wdata;
    if (!e_access || bus.mem_ready) m_wait = 0;
    else if (m_wait < TO) m_wait++;
    if (m_wait >= TO) m_to = 1'b1;
    if (p0_served && bus.mem_ready) p0_served = 1'b0;
    else if (cap_en) begin
      p0_served = 1'b1;
      m_hold    = cap;
    end
    if (!rst_n) begin
      m_valid   = 1'b1;
      p0_served = 1'b0;
      m_hold    = '0;
      m_wait    = 0;
      m_to      = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [2:0] op0, input logic [AW-1:0] a0, input logic [DW-1:0] w0,
                        input logic [2:0] op1, input logic [AW-1:0] a1, input logic [DW-1:0] w1,
                        input logic rdy);
    @(posedge clk);
    #1;
    pre_en          = 1'b0;
    bus.p0S3_opcode = op0; bus.p0S3_addr = a0; bus.p0S3_wdata = w0;
    bus.p1S3_opcode = op1; bus.p1S3_addr = a1; bus.p1S3_wdata = w1;
    bus.mem_ready   = rdy;
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    bus.p0S3_opcode = NOP;
    bus.p1S3_opcode = NOP;
    bus.mem_ready   = 1'b1;
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic idle();
    set_in(NOP, 8'h00, 16'h0, NOP, 8'h00, 16'h0, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.p0S3_opcode = NOP; bus.p0S3_addr = '0; bus.p0S3_wdata = '0;
    bus.p1S3_opcode = NOP; bus.p1S3_addr = '0; bus.p1S3_wdata = '0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_read",    32'(bus.mem_read),    32'd0);
    check("rst_write",   32'(bus.mem_write),   32'd0);
    check("rst_addr",    32'(bus.mem_addr),    32'd0);
    check("rst_stall",   32'(bus.mem_stall),   32'd0);
    check("rst_timeout", 32'(bus.mem_timeout), 32'd0);

    // single LDR on P0
    preload(8'h10, 16'hAAAA);
    set_in(LDR, 8'h10, 16'h0, ADD, 8'h99, 16'h0, 1'b1);
    check("t1_read",  32'(bus.mem_read),  32'd1);
    check("t1_addr",  32'(bus.mem_addr),  32'h10);
    check("t1_stall", 32'(bus.mem_stall), 32'd0);
    check("t1_p0",    32'(bus.p0_rdata),  32'hAAAA);

    // LDR + LDR: one stall cycle
    preload(8'h10, 16'h1111);
    preload(8'h20, 16'h2222);
    set_in(LDR, 8'h10, 16'h0, LDR, 8'h20, 16'h0, 1'b1);
    check("t2_c0_addr",  32'(bus.mem_addr),  32'h10);
    check("t2_c0_stall", 32'(bus.mem_stall), 32'd1);
    next_cycle();
    check("t2_c1_addr",  32'(bus.mem_addr),  32'h20);
    check("t2_c1_stall", 32'(bus.mem_stall), 32'd0);
    check("t2_c1_p0",    32'(bus.p0_rdata),  32'h1111);
    check("t2_c1_p1",    32'(bus.p1_rdata),  32'h2222);

    // STR then LDR to the same address
    preload(8'h30, 16'h0000);
    set_in(STR, 8'h30, 16'h5A5A, LDR, 8'h30, 16'h0, 1'b1);
    check("t3_c0_write", 32'(bus.mem_write), 32'd1);
    check("t3_c0_wdata", 32'(bus.mem_wdata), 32'h5A5A);
    next_cycle();
    check("t3_c1_write", 32'(bus.mem_write), 32'd0);
    check("t3_c1_p1",    32'(bus.p1_rdata),  32'h5A5A);

    // P1-only STR stretched by 3 not-ready cycles
    preload(8'h40, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      set_in(NOP, 8'h00, 16'h0, STR, 8'h40, 16'h1234, 1'b0);
      check("t4_wait_stall", 32'(bus.mem_stall), 32'd1);
      check("t4_wait_write", 32'(bus.mem_write), 32'd1);
      check("t4_wait_addr",  32'(bus.mem_addr),  32'h40);
    end
    set_in(NOP, 8'h00, 16'h0, STR, 8'h40, 16'h1234, 1'b1);
    check("t4_done_stall", 32'(bus.mem_stall), 32'd0);
    idle();
    check("t4_mem", 32'(mem[8'h40]), 32'h1234);

    // LDR then STR to the same address: P0 sees the old value
    preload(8'h50, 16'h0BAD);
    set_in(LDR, 8'h50, 16'h0, STR, 8'h50, 16'hBEEF, 1'b1);
    next_cycle();
    check("t5_p0_old", 32'(bus.p0_rdata), 32'h0BAD);
    idle();
    check("t5_mem", 32'(mem[8'h50]), 32'hBEEF);

    // timeout after TO not-ready cycles, sticky afterwards
    preload(8'h60, 16'h6666);
    for (int i = 0; i < TO; i++) begin
      set_in(LDR, 8'h60, 16'h0, NOP, 8'h00, 16'h0, 1'b0);
      check("t6_no_timeout", 32'(bus.mem_timeout), 32'd0);
    end
    next_cycle();
    check("t6_timeout", 32'(bus.mem_timeout), 32'd1);
    set_in(LDR, 8'h60, 16'h0, NOP, 8'h00, 16'h0, 1'b1);
    check("t6_p0", 32'(bus.p0_rdata), 32'h6666);
    idle();
    check("t6_sticky", 32'(bus.mem_timeout), 32'd1);

    // reset while granted to P1
    set_in(LDR, 8'h10, 16'h0, LDR, 8'h20, 16'h0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("t7_in_p1", 32'(state_o), 32'd1);
    check("t7_hold",  32'(hold_o),  32'h1111);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.p0S3_opcode = STR; bus.p0S3_addr = 8'h70; bus.p0S3_wdata = 16'h7777;
    bus.p1S3_opcode = NOP; bus.p1S3_addr = 8'h00; bus.p1S3_wdata = 16'h0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("t7_state",   32'(state_o),         32'd0);
    check("t7_write",   32'(bus.mem_write),   32'd1);
    check("t7_addr",    32'(bus.mem_addr),    32'h70);
    check("t7_hold0",   32'(hold_o),          32'h0);
    check("t7_timeout", 32'(bus.mem_timeout), 32'd0);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
